// File: rtl/dht11_scheduler.sv
// DHT11 single-wire sensor controller: bus-mapped registers, protocol FSM on a 1 us tick,
// periodic auto-sampling and a minimum idle gap between transactions.
module dht11_scheduler #(
  parameter int CLK_MHZ       = 50,
  parameter int DEF_PERIOD_MS = 2000,
  parameter int TIMEOUT_US    = 120,
  parameter int START_US      = 18000,
  parameter int US_PER_MS     = 1000,
  parameter int GAP_MS        = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  inout  wire         DHT11,
  output logic        sample_done
);
  localparam int          DIV_W  = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [31:0] GAP_US = 32'(GAP_MS * US_PER_MS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RELEASE, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_sync;
  logic             r_drive_low, r_done;
  logic [15:0]      r_ph_us, r_period, r_ok_cnt, r_err_cnt;
  logic [5:0]       r_bit_cnt;
  logic [39:0]      r_shift;
  logic [31:0]      r_data, r_dout, r_gap_us, r_per_us;
  logic             r_valid, r_err_ck, r_err_to, r_auto_en, r_pend_trig, r_pend_auto;

  logic        w_tick, w_line, w_busy, w_waiting, w_ctrl_wr, w_per_wr, w_rd, w_unused;
  logic [7:0]  w_sum;
  logic [31:0] w_period_us;

  assign w_tick      = (r_div == DIV_W'(CLK_MHZ - 1));
  assign w_line      = r_sync[1];
  assign w_busy      = (r_state != S_IDLE);
  assign w_waiting   = (r_state inside {S_RELEASE, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH});
  assign w_ctrl_wr   = cs && wr && (addr[3:0] == 4'h0);
  assign w_per_wr    = cs && wr && (addr[3:0] == 4'h8);
  assign w_rd        = cs && rd;
  assign w_sum       = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];
  assign w_period_us = {16'b0, r_period} * 32'(US_PER_MS);
  assign w_unused    = ^{addr[31:4], d_in[31:16]};

  assign DHT11       = r_drive_low ? 1'b0 : 1'bz;
  assign d_out       = r_dout;
  assign sample_done = r_done;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div  <= '0;
      r_sync <= 2'b11;
    end else begin
      // NOTE: every clocked register uses <= so all flops see pre-edge values regardless of statement order.
      r_div  <= w_tick ? '0 : r_div + DIV_W'(1);
      r_sync <= {r_sync[0], DHT11};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_drive_low <= 1'b0;
      r_done      <= 1'b0;
      r_ph_us     <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_err_ck    <= 1'b0;
      r_err_to    <= 1'b0;
      r_ok_cnt    <= '0;
      r_err_cnt   <= '0;
      r_auto_en   <= 1'b0;
      r_period    <= 16'(DEF_PERIOD_MS);
      r_gap_us    <= '0;
      r_per_us    <= '0;
      r_pend_trig <= 1'b0;
      r_pend_auto <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_tick && w_busy)        r_ph_us  <= r_ph_us + 16'd1;
      if (w_tick && r_gap_us != 0) r_gap_us <= r_gap_us - 32'd1;

      // Period counter stops at expiry so a late (busy) expiry leaves a single pending start.
      if (!r_auto_en) begin
        r_per_us    <= '0;
        r_pend_auto <= 1'b0;
      end else if (w_tick) begin
        if (r_per_us + 32'd1 >= w_period_us) r_pend_auto <= 1'b1;
        else                                 r_per_us    <= r_per_us + 32'd1;
      end

      if (w_ctrl_wr) begin
        r_auto_en <= d_in[1];
        if (d_in[0] && !w_busy) r_pend_trig <= 1'b1;
      end
      if (w_per_wr) r_period <= (d_in[15:0] == 16'd0) ? 16'd1 : d_in[15:0];

      case (r_state)
        S_IDLE: if (r_gap_us == 0 && (r_pend_trig || r_pend_auto)) begin
          r_state     <= S_START;
          r_drive_low <= 1'b1;
          r_ph_us     <= '0;
          r_pend_trig <= 1'b0;
          r_pend_auto <= 1'b0;
          r_per_us    <= '0;
        end
        S_START: if (w_tick && r_ph_us == 16'(START_US - 1)) begin
          r_state     <= S_RELEASE;
          r_drive_low <= 1'b0;
          r_ph_us     <= '0;
        end
        // Skip the first few us so the synchronizer's view of our own low is not taken as a reply.
        S_RELEASE: if (!w_line && r_ph_us >= 16'd5) begin
          r_state <= S_RESP_LOW;
          r_ph_us <= '0;
        end
        S_RESP_LOW: if (w_line) begin
          r_state <= S_RESP_HIGH;
          r_ph_us <= '0;
        end
        S_RESP_HIGH: if (!w_line) begin
          r_state   <= S_BIT_LOW;
          r_ph_us   <= '0;
          r_bit_cnt <= '0;
        end
        S_BIT_LOW: if (w_line) begin
          r_state <= S_BIT_HIGH;
          r_ph_us <= '0;
        end
        S_BIT_HIGH: if (!w_line) begin
          r_shift <= {r_shift[38:0], (r_ph_us > 16'd40)};
          r_ph_us <= '0;
          if (r_bit_cnt == 6'd39) r_state <= S_CHECK;
          else begin
            r_state   <= S_BIT_LOW;
            r_bit_cnt <= r_bit_cnt + 6'd1;
          end
        end
        S_CHECK: begin
          if (w_sum == r_shift[7:0]) begin
            r_data   <= r_shift[39:8];
            r_valid  <= 1'b1;
            r_err_ck <= 1'b0;
            r_ok_cnt <= sat_inc(r_ok_cnt);
          end else begin
            r_err_ck  <= 1'b1;
            r_err_cnt <= sat_inc(r_err_cnt);
          end
          r_state  <= S_IDLE;
          r_done   <= 1'b1;
          r_gap_us <= GAP_US;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_waiting && w_tick && r_ph_us >= 16'(TIMEOUT_US)) begin
        r_state   <= S_IDLE;
        r_err_to  <= 1'b1;
        r_err_cnt <= sat_inc(r_err_cnt);
        r_done    <= 1'b1;
        r_gap_us  <= GAP_US;
      end

      if (w_ctrl_wr && d_in[2]) begin
        r_err_ck  <= 1'b0;
        r_err_to  <= 1'b0;
        r_ok_cnt  <= '0;
        r_err_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_dout <= '0;
    else if (w_rd) begin
      case (addr[3:0])
        4'h0:    r_dout <= {27'b0, r_err_to, r_err_ck, r_valid, w_busy, r_auto_en};
        4'h4:    r_dout <= r_data;
        4'h8:    r_dout <= {16'b0, r_period};
        4'hC:    r_dout <= {r_err_cnt, r_ok_cnt};
        default: r_dout <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_dht11_scheduler.sv
// Self-checking bench for dht11_scheduler: behavioural DHT11 sensor on a pulled-up line,
// a register-level reference model, directed protocol/scheduling cases and random frames.
`timescale 1ns/1ps
module tb_dht11_scheduler;
  localparam int CLK_MHZ    = 1;
  localparam int TIMEOUT_US = 120;
  localparam int START_US   = 500;
  localparam int US_PER_MS  = 4;
  localparam int GAP_MS     = 250;
  localparam int GAP_US     = GAP_MS * US_PER_MS;
  localparam logic [39:0] GOOD = 40'h37_00_19_00_50;
  localparam logic [39:0] BAD  = 40'h37_00_19_00_51;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] d_in = '0, addr = '0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [31:0] d_out;
  logic        sample_done;
  logic        sens_low = 1'b0;
  wire         dht_line;

  assign dht_line = sens_low ? 1'b0 : 1'bz;
  pullup (dht_line);
  always #5 clk = ~clk;

  dht11_scheduler #(
    .CLK_MHZ(CLK_MHZ), .DEF_PERIOD_MS(2000), .TIMEOUT_US(TIMEOUT_US),
    .START_US(START_US), .US_PER_MS(US_PER_MS), .GAP_MS(GAP_MS)
  ) dut (
    .clk(clk), .reset(rst_n), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .DHT11(dht_line), .sample_done(sample_done)
  );

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] clamp(input int v, input int lo, input int hi);
    return 32'((v < lo) ? lo : (v > hi) ? hi : v);
  endfunction

  int cyc = 0, done_cnt = 0, done_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (sample_done) begin
    done_cnt <= done_cnt + 1;
    done_cyc <= cyc;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sensor: detects a host start, records its time, answers with `frame` unless silent.
  logic [39:0] frame = GOOD;
  bit          model_silent = 1'b0, sens_high_phase = 1'b0;
  int          start_q[$];
  int          rel_cyc = 0, bit_idx = -1;
  initial begin
    forever begin
      @(negedge clk);
      if (dht_line === 1'b0) begin
        start_q.push_back(cyc);
        while (dht_line !== 1'b1) @(negedge clk);
        rel_cyc = cyc;
        if (!model_silent) begin
          hold(30); sens_low = 1'b1; hold(80); sens_low = 1'b0; hold(80);
          for (int i = 0; i < 40; i++) begin
            bit_idx = i;
            sens_low = 1'b1; hold(50); sens_low = 1'b0;
            sens_high_phase = 1'b1; hold(frame[39-i] ? 70 : 26); sens_high_phase = 1'b0;
          end
          sens_low = 1'b1; hold(50); sens_low = 1'b0;
          bit_idx = -1;
        end
      end
    end
  end

  // Reference model of the visible register state.
  logic [31:0] e_data;
  logic [15:0] e_ok, e_err, e_period;
  bit          e_valid, e_ck, e_to, e_auto;

  task automatic exp_reset();
    e_data = '0; e_ok = '0; e_err = '0; e_period = 16'd2000;
    e_valid = 0; e_ck = 0; e_to = 0; e_auto = 0;
  endtask

  task automatic exp_frame(input logic [39:0] f, input bit silent);
    int s;
    if (silent) begin
      e_to = 1;
      if (e_err != 16'hFFFF) e_err++;
    end else begin
      s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
      if (s == int'(f[7:0])) begin
        e_data = f[39:8]; e_valid = 1; e_ck = 0;
        if (e_ok != 16'hFFFF) e_ok++;
      end else begin
        e_ck = 1;
        if (e_err != 16'hFFFF) e_err++;
      end
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; d_in = d; cs = 1'b1; wr = 1'b1;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; cs = 1'b1; rd = 1'b1;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    d = d_out;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    bus_read(32'h0, v); check({tag, "_status"}, v, {27'b0, e_to, e_ck, e_valid, 1'b0, e_auto});
    bus_read(32'h4, v); check({tag, "_data"}, v, e_data);
    bus_read(32'hC, v); check({tag, "_counts"}, v, {e_err, e_ok});
    bus_read(32'h8, v); check({tag, "_period"}, v, {16'b0, e_period});
  endtask

  task automatic wait_start(input int n, input int budget, input string tag);
    int k = 0;
    while (start_q.size() < n && k < budget) begin @(negedge clk); k++; end
    check({tag, "_start_seen"}, 32'(start_q.size() >= n), 1);
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin @(negedge clk); k++; end
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
  endtask

  task automatic run_frame(input string tag, input logic [39:0] f, input bit silent,
                           input bit poke, output int trig_cyc, output int st_cyc);
    int d0, s0;
    logic [31:0] v;
    frame = f; model_silent = silent;
    d0 = done_cnt; s0 = start_q.size(); trig_cyc = cyc;
    bus_write(32'h0, {30'b0, e_auto, 1'b1});
    wait_start(s0 + 1, GAP_US + 50, tag);
    st_cyc = (start_q.size() > s0) ? start_q[s0] : -1;
    if (poke) begin
      hold(300);
      bus_write(32'h0, {30'b0, e_auto, 1'b1});
      bus_read(32'h4, v); check({tag, "_data_while_busy"}, v, e_data);
      bus_read(32'h0, v); check({tag, "_busy"}, 32'(v[1]), 1);
    end
    wait_done(d0, 8000, tag);
    hold(3);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
    exp_frame(f, silent);
    check_regs(tag);
    if (poke) begin
      hold(GAP_US + 20);
      check({tag, "_one_start"}, 32'(start_q.size() - s0), 1);
    end
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  b [4];
    logic [39:0] f;
    int tc, sc, s0, d0, s, k, e2;

    exp_reset();
    hold(3);
    check("rst_dout", d_out, 0);
    check("rst_done", 32'(sample_done), 0);
    check("rst_line", 32'(dht_line), 1);
    rst_n = 1'b1;
    hold(2);
    check_regs("reset");
    bus_read(32'h6, v); check("unmapped_read", v, 0);
    bus_write(32'h8, 32'h0); bus_read(32'h8, v); check("period_zero_as_one", v, 1);
    bus_write(32'h8, 32'd2000);

    // Valid frame, first trigger after reset starts at once.
    run_frame("pass", GOOD, 0, 0, tc, sc);
    check("first_trigger_immediate", clamp(sc - tc, 1, 4), 32'(sc - tc));
    // Bad checksum; trigger issued inside the gap is held until gap end.
    s = done_cyc;
    run_frame("cksum", BAD, 0, 0, tc, sc);
    check("held_trigger_gap", clamp(sc - s, GAP_US, GAP_US + 3), 32'(sc - s));
    // Silent sensor.
    run_frame("timeout", GOOD, 1, 0, tc, sc);
    check("timeout_latency", clamp(done_cyc - rel_cyc, 115, 130), 32'(done_cyc - rel_cyc));
    check("timeout_line_released", 32'(dht_line), 1);
    bus_write(32'h0, 32'h4);
    e_ok = '0; e_err = '0; e_ck = 0; e_to = 0;
    check_regs("clear");

    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) b[j] = 8'($urandom);
      s = int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
      f = {b[0], b[1], b[2], b[3],
           ($urandom_range(1, 0) == 1) ? 8'(s) : 8'(s + int'($urandom_range(255, 1)))};
      run_frame($sformatf("rand%0d", i), f, 0, (i != 1), tc, sc);
    end

    // Auto mode: trigger lands on the same edge as the first expiry, then 1500 ms spacing.
    bus_write(32'h8, 32'd1500); e_period = 16'd1500;
    hold(GAP_US + 10);
    frame = GOOD; model_silent = 0;
    d0 = done_cnt; s0 = start_q.size();
    bus_write(32'h0, 32'h2); e_auto = 1;
    hold(1500 * US_PER_MS - 1);
    bus_write(32'h0, 32'h3);
    wait_start(s0 + 1, 50, "same_cycle");
    wait_done(d0, 8000, "auto1"); exp_frame(GOOD, 0);
    wait_start(s0 + 2, 8000, "auto2");
    if (start_q.size() >= s0 + 2) begin
      s = start_q[s0 + 1] - start_q[s0];
      check("auto_spacing_1500", clamp(s, 1500 * US_PER_MS, 1500 * US_PER_MS + 3), 32'(s));
    end
    bus_write(32'h8, 32'd200); e_period = 16'd200;
    d0 = done_cnt;
    wait_done(d0, 8000, "auto2"); exp_frame(GOOD, 0);
    e2 = done_cyc;
    wait_start(s0 + 3, GAP_US + 50, "auto3");
    if (start_q.size() >= s0 + 3) begin
      s = start_q[s0 + 2] - e2;
      check("auto_gap_200", clamp(s, GAP_US, GAP_US + 3), 32'(s));
      s = start_q[s0 + 2] - start_q[s0 + 1];
      check("auto_spacing_200", clamp(s, GAP_US + 4000, GAP_US + 6000), 32'(s));
    end
    bus_write(32'h0, 32'h0); e_auto = 0;
    d0 = done_cnt;
    wait_done(d0, 8000, "auto3"); exp_frame(GOOD, 0);
    hold(3);
    check_regs("auto_end");
    hold(GAP_US + 1000);
    check("auto_off_starts", 32'(start_q.size() - s0), 3);

    // Reset while the host is driving the start pulse.
    model_silent = 1; s0 = start_q.size();
    bus_write(32'h0, 32'h1);
    wait_start(s0 + 1, 50, "rst_start");
    hold(100);
    rst_n = 1'b0;
    #1;
    check("rst_start_line_released", 32'(dht_line), 1);
    check("rst_start_dout", d_out, 0);
    hold(2);
    rst_n = 1'b1;
    exp_reset();
    hold(2);

    // Reset during bit 20, then a normal transaction.
    frame = GOOD; model_silent = 0;
    bus_write(32'h0, 32'h1);
    k = 0;
    while (!(bit_idx == 20 && sens_high_phase) && k < 8000) begin @(negedge clk); k++; end
    check("bit20_reached", 32'(bit_idx == 20), 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_bit20_line", 32'(dht_line), 1);
    check("rst_bit20_dout", d_out, 0);
    hold(3);
    rst_n = 1'b1;
    exp_reset();
    hold(2500);
    check("rst_bit20_no_done", 32'(done_cnt - d0), 0);
    check_regs("after_rst");
    run_frame("post_rst", GOOD, 0, 0, tc, sc);
    check("post_rst_immediate", clamp(sc - tc, 1, 4), 32'(sc - tc));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dht11_scheduler.md
DHT11_SCHEDULER -- requirements
Module: dht11_scheduler

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 50, meaning clk cycles per microsecond for the internal 1 us tick.
REQ-002 SHALL have parameter DEF_PERIOD_MS, default 2000, meaning the reset value of the auto-sample period register.
REQ-003 SHALL have parameter TIMEOUT_US, default 120, meaning the maximum wait in any sensor-response or bit phase.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have bus ports d_in (input, 32), cs (input, 1), addr (input, 32), rd (input, 1), wr (input, 1) and d_out (output, 32 registered): peripheral bus.
REQ-007 SHALL have port DHT11, inout, 1 bit: open-drain sensor line, driven only 0 or Z.
REQ-008 SHALL have port sample_done, output, 1 bit: one-cycle pulse when a transaction ends, pass or fail.

Function
REQ-009 SHALL sample DHT11 through a 2-flop synchronizer; all protocol timing SHALL use the 1 us tick (divide by CLK_MHZ).
REQ-010 SHALL register map (addr[3:0]): 0x0 CTRL/STATUS, 0x4 DATA, 0x8 PERIOD_MS[15:0], 0xC COUNTS {err_cnt[15:0], ok_cnt[15:0]}; other offsets SHALL read 0.
REQ-011 SHALL write on cs&wr: CTRL bit0 = trigger (self-clearing), bit1 = auto_en, bit2 = clear errors/counters; PERIOD write of 0 SHALL be stored as 1.
REQ-012 SHALL read CTRL/STATUS as {27'b0, err_timeout, err_cksum, valid, busy, auto_en}; d_out SHALL update one cycle after cs&rd and otherwise hold.
REQ-013 SHALL implement the FSM IDLE -> START_LOW (drive 0 for 18000 us) -> RELEASE (Z, wait for low up to TIMEOUT_US) -> RESP_LOW (wait for rise) -> RESP_HIGH (wait for fall) -> BIT_LOW -> BIT_HIGH (x40) -> CHECK -> IDLE.
REQ-014 SHALL decode each bit as 1 if its high time is >40 us, else 0, shifting MSB-first into a 40-bit register.
REQ-015 SHALL, in CHECK, pass if byte0+byte1+byte2+byte3 (mod 256) equals byte4; on pass DATA <= bytes 0..3, valid <= 1, err_cksum <= 0, ok_cnt += 1.
REQ-016 SHALL, on checksum fail, leave DATA unchanged, set err_cksum and increment err_cnt.
REQ-017 SHALL, if any wait in RELEASE..BIT_HIGH exceeds TIMEOUT_US, go to IDLE, set err_timeout, increment err_cnt and pulse sample_done.
REQ-018 SHALL saturate counters at 16'hFFFF.
REQ-019 SHALL hold busy = 1 in every state except IDLE.
REQ-020 SHALL, when auto_en = 1, start a transaction every PERIOD_MS ms measured start-to-start; a period expiring while busy SHALL be deferred until IDLE and not queued twice.
REQ-021 SHALL enforce a minimum 1000 ms gap from the end of one transaction to the next start; triggers arriving inside the gap SHALL be held and serviced at gap end.
REQ-022 SHALL ignore a trigger written while busy.
REQ-023 SHALL give a same-cycle trigger write and auto expiry exactly one transaction.
REQ-024 SHALL let a bus read of DATA during a transaction return the last valid value, never partial shift data.
REQ-025 SHALL never drive DHT11 high.

Reset
REQ-026 SHALL, on reset low, immediately set: FSM IDLE, DHT11 = Z, d_out = 0, sample_done = 0, DATA = 0, valid/err flags = 0, counters = 0, auto_en = 0, PERIOD = DEF_PERIOD_MS, gap timer expired (first trigger starts at once).
REQ-027 SHALL, if reset asserts mid-transaction, release the line within the same cycle (asynchronous) and discard partial data.

Verification
REQ-028 SHALL cover: write CTRL=0x1, sensor model returns 0x37,0x00,0x19,0x00,0x50 -> DATA=0x37001900, valid=1, ok_cnt=1, sample_done one pulse.
REQ-029 SHALL cover: model returns checksum 0x51 -> DATA unchanged, err_cksum=1, err_cnt=1.
REQ-030 SHALL cover: model never answers after release -> err_timeout=1 about 120 us after release, FSM IDLE, line Z.
REQ-031 SHALL cover: auto_en=1, PERIOD=1500 -> starts spaced 1500 ms; PERIOD=200 -> spacing is at least 1000 ms gap plus transaction time.
REQ-032 SHALL cover: reset pulled low during bit 20 -> line Z at once, d_out=0, no sample_done; after release trigger works normally.
REQ-033 SHALL cover: trigger written while busy, and trigger plus auto expiry in the same cycle -> exactly one transaction each case.
